// File: rtl/alu_mc_if.sv
// alu_mc_if: operand/opcode request and result/flags response channels of alu_mc.
// The master drives requests and takes results; the slave (the ALU) does the reverse.
interface alu_mc_if #(
    parameter int DATA_WIDTH = 16,
    parameter int OP_WIDTH   = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] alu_a_in;
    logic [DATA_WIDTH-1:0] alu_b_in;
    logic [OP_WIDTH-1:0]   alu_op;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] alu_dout;
    logic [DATA_WIDTH-1:0] alu_flags;

    modport master (
        output in_valid, alu_a_in, alu_b_in, alu_op, out_ready,
        input  in_ready, out_valid, alu_dout, alu_flags
    );

    modport slave (
        input  in_valid, alu_a_in, alu_b_in, alu_op, out_ready,
        output in_ready, out_valid, alu_dout, alu_flags
    );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU; 1-cycle ops, DATA_WIDTH+1 cycles for shift-add MUL/MULH and restoring DIVU/REMU.
// in_ready only in IDLE, result held until out_ready; define ALU_DIV_EN to build the divider (else 13/14 are illegal).
module alu_mc #(
    parameter int DATA_WIDTH = 16,
    parameter int OP_WIDTH   = 4
) (
    input logic     clk,
    input logic     rst,
    alu_mc_if.slave bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [OP_WIDTH-1:0] OP_ADD  = OP_WIDTH'(0);
    localparam logic [OP_WIDTH-1:0] OP_SUB  = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] OP_SRL  = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] OP_SLL  = OP_WIDTH'(3);
    localparam logic [OP_WIDTH-1:0] OP_OR   = OP_WIDTH'(4);
    localparam logic [OP_WIDTH-1:0] OP_NOR  = OP_WIDTH'(5);
    localparam logic [OP_WIDTH-1:0] OP_AND  = OP_WIDTH'(6);
    localparam logic [OP_WIDTH-1:0] OP_NAND = OP_WIDTH'(7);
    localparam logic [OP_WIDTH-1:0] OP_XOR  = OP_WIDTH'(8);
    localparam logic [OP_WIDTH-1:0] OP_NOT  = OP_WIDTH'(9);
    localparam logic [OP_WIDTH-1:0] OP_SRA  = OP_WIDTH'(10);
    localparam logic [OP_WIDTH-1:0] OP_MUL  = OP_WIDTH'(11);
    localparam logic [OP_WIDTH-1:0] OP_MULH = OP_WIDTH'(12);
`ifdef ALU_DIV_EN
    localparam logic [OP_WIDTH-1:0] OP_DIVU = OP_WIDTH'(13);
    localparam logic [OP_WIDTH-1:0] OP_REMU = OP_WIDTH'(14);
`endif

    localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);

    logic [1:0]    r_state;
    logic [W-1:0]  r_dout;
    logic [W-1:0]  r_flags;
    logic [W-1:0]  r_hi;
    logic [W-1:0]  r_lo;
    logic [W-1:0]  r_b;
    logic [CW-1:0] r_cnt;
    logic          r_is_hi;
`ifdef ALU_DIV_EN
    logic          r_is_div;
`endif

    logic [W-1:0] w_a;
    logic [W-1:0] w_b;
    logic [W:0]   w_add;
    logic [W:0]   w_sub;
    logic [W-1:0] w_res;
    logic         w_c;
    logic         w_v;
    logic         w_dz;
    logic         w_ill;
    logic         w_multi;
    logic         w_accept;

    assign w_a      = bus.alu_a_in;
    assign w_b      = bus.alu_b_in;
    assign w_add    = {1'b0, w_a} + {1'b0, w_b};
    assign w_sub    = {1'b0, w_a} - {1'b0, w_b};
    assign w_accept = bus.in_valid && (r_state == S_IDLE);

    function automatic logic [W-1:0] pack_flags(input logic [W-1:0] res, input logic c,
                                                 input logic v, input logic dz, input logic ill);
        logic [W-1:0] f;
        f      = '0;
        f[5:0] = {ill, dz, v, c, res[W-1], (res == '0)};
        return f;
    endfunction

    always_comb begin
        w_res   = '0;
        w_c     = 1'b0;
        w_v     = 1'b0;
        w_dz    = 1'b0;
        w_ill   = 1'b0;
        w_multi = 1'b0;
        case (bus.alu_op)
            OP_ADD: begin
                w_res = w_add[W-1:0];
                w_c   = w_add[W];
                w_v   = (w_a[W-1] == w_b[W-1]) && (w_add[W-1] != w_a[W-1]);
            end
            OP_SUB: begin
                w_res = w_sub[W-1:0];
                w_c   = ~w_sub[W];
                w_v   = (w_a[W-1] != w_b[W-1]) && (w_sub[W-1] != w_a[W-1]);
            end
            // Full-width shift amounts naturally flush to zero / sign.
            OP_SRL:  w_res = w_a >> w_b;
            OP_SLL:  w_res = w_a << w_b;
            OP_SRA:  w_res = $signed(w_a) >>> w_b;
            OP_OR:   w_res = w_a | w_b;
            OP_NOR:  w_res = ~(w_a | w_b);
            OP_AND:  w_res = w_a & w_b;
            OP_NAND: w_res = ~(w_a & w_b);
            OP_XOR:  w_res = w_a ^ w_b;
            OP_NOT:  w_res = ~w_a;
            OP_MUL, OP_MULH: w_multi = 1'b1;
`ifdef ALU_DIV_EN
            OP_DIVU: begin
                if (w_b == '0) begin
                    w_res = '1;
                    w_dz  = 1'b1;
                end else begin
                    w_multi = 1'b1;
                end
            end
            OP_REMU: begin
                if (w_b == '0) begin
                    w_res = w_a;
                    w_dz  = 1'b1;
                end else begin
                    w_multi = 1'b1;
                end
            end
`endif
            default: w_ill = 1'b1;
        endcase
    end

    // Shift-add step: {hi,lo} holds partial product over the remaining multiplier bits.
    logic [W:0]   w_mul_sum;
    logic [W-1:0] w_hi_n;
    logic [W-1:0] w_lo_n;

    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(W+1){1'b0}});

`ifdef ALU_DIV_EN
    // Restoring step: hi is the partial remainder, lo shifts dividend out and quotient in.
    logic [W:0] w_div_sh;
    logic [W:0] w_div_sub;
    logic       w_qbit;

    assign w_div_sh  = {r_hi, r_lo[W-1]};
    assign w_div_sub = w_div_sh - {1'b0, r_b};
    assign w_qbit    = ~w_div_sub[W];

    always_comb begin
        if (r_is_div) begin
            w_hi_n = w_qbit ? w_div_sub[W-1:0] : w_div_sh[W-1:0];
            w_lo_n = {r_lo[W-2:0], w_qbit};
        end else begin
            w_hi_n = w_mul_sum[W:1];
            w_lo_n = {w_mul_sum[0], r_lo[W-1:1]};
        end
    end
`else
    assign w_hi_n = w_mul_sum[W:1];
    assign w_lo_n = {w_mul_sum[0], r_lo[W-1:1]};
`endif

    logic [W-1:0] w_iter_res;
    assign w_iter_res = r_is_hi ? w_hi_n : w_lo_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_dout   <= '0;
            r_flags  <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_is_hi  <= 1'b0;
`ifdef ALU_DIV_EN
            r_is_div <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_multi) begin
                            r_state  <= S_BUSY;
                            r_hi     <= '0;
                            r_lo     <= w_a;
                            r_b      <= w_b;
                            r_cnt    <= '0;
`ifdef ALU_DIV_EN
                            r_is_hi  <= (bus.alu_op == OP_MULH) || (bus.alu_op == OP_REMU);
                            r_is_div <= (bus.alu_op == OP_DIVU) || (bus.alu_op == OP_REMU);
`else
                            r_is_hi  <= (bus.alu_op == OP_MULH);
`endif
                        end else begin
                            r_state <= S_DONE;
                            r_dout  <= w_res;
                            r_flags <= pack_flags(w_res, w_c, w_v, w_dz, w_ill);
                        end
                    end
                end
                S_BUSY: begin
                    r_hi  <= w_hi_n;
                    r_lo  <= w_lo_n;
                    r_cnt <= r_cnt + CW'(1);
                    // Last iteration retires straight into the output register.
                    if (r_cnt == LAST_ITER) begin
                        r_state <= S_DONE;
                        r_dout  <= w_iter_res;
                        r_flags <= pack_flags(w_iter_res, 1'b0, 1'b0, 1'b0, 1'b0);
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.alu_dout  = r_dout;
    assign bus.alu_flags = r_flags;

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed plan cases plus randomized ops checked against an arithmetic reference model.
module tb_alu_mc;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_mc_if #(.DATA_WIDTH(W), .OP_WIDTH(4)) bus ();
    alu_mc #(.DATA_WIDTH(W), .OP_WIDTH(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int n_cmp = 0;
    int n_err = 0;
    int cur_op = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s (op %0d): observed %0h expected %0h", tag, cur_op, obs, exp);
        end
    endtask

    // Returns {result, flags}.
    function automatic logic [31:0] model(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
        int ua, ub, sa, sb, s;
        longint p;
        logic [15:0] r;
        logic c, v, dz, ill;
        ua = a; ub = b; sa = $signed(a); sb = $signed(b);
        p = longint'(ua) * longint'(ub);
        r = 16'h0; c = 1'b0; v = 1'b0; dz = 1'b0; ill = 1'b0;
        case (op)
            4'd0: begin
                s = ua + ub; r = s[15:0]; c = (s > 65535);
                s = sa + sb; v = (s > 32767) || (s < -32768);
            end
            4'd1: begin
                s = ua - ub; r = s[15:0]; c = (ua >= ub);
                s = sa - sb; v = (s > 32767) || (s < -32768);
            end
            4'd2:  r = (ub >= 16) ? 16'h0 : a >> ub;
            4'd3:  r = (ub >= 16) ? 16'h0 : a << ub;
            4'd4:  r = a | b;
            4'd5:  r = ~(a | b);
            4'd6:  r = a & b;
            4'd7:  r = ~(a & b);
            4'd8:  r = a ^ b;
            4'd9:  r = ~a;
            4'd10: begin s = sa >>> ((ub >= 16) ? 15 : ub); r = s[15:0]; end
            4'd11: r = p[15:0];
            4'd12: r = p[31:16];
            4'd13: begin
`ifdef ALU_DIV_EN
                if (ub == 0) begin r = 16'hFFFF; dz = 1'b1; end
                else begin s = ua / ub; r = s[15:0]; end
`else
                ill = 1'b1;
`endif
            end
            4'd14: begin
`ifdef ALU_DIV_EN
                if (ub == 0) begin r = a; dz = 1'b1; end
                else begin s = ua % ub; r = s[15:0]; end
`else
                ill = 1'b1;
`endif
            end
            default: ill = 1'b1;
        endcase
        return {r, 10'b0, ill, dz, v, c, r[15], (r == 16'h0)};
    endfunction

    function automatic int exp_lat(input logic [3:0] op, input logic [15:0] b);
        if (op == 4'd11 || op == 4'd12) return W + 1;
`ifdef ALU_DIV_EN
        if ((op == 4'd13 || op == 4'd14) && b != 16'h0) return W + 1;
`endif
        return 1;
    endfunction

    task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          input int hold, output logic [15:0] dout, output logic [15:0] flags);
        logic [31:0] exp;
        int bound, lat;
        logic busy_ok;
        cur_op = op;
        exp = model(op, a, b);
        bound = 0;
        while (!bus.in_ready && bound < 50) begin
            @(posedge clk); #1; bound++;
        end
        chk("in_ready_wait", bus.in_ready, 1);
        bus.alu_op = op; bus.alu_a_in = a; bus.alu_b_in = b;
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(posedge clk); #1;
        // Scramble inputs after accept: captured operands must be used.
        bus.in_valid = 1'b0;
        bus.alu_a_in = 16'($urandom); bus.alu_b_in = 16'($urandom); bus.alu_op = 4'($urandom);
        lat = 1; busy_ok = 1'b1;
        while (!bus.out_valid && lat < 100) begin
            if (bus.in_ready) busy_ok = 1'b0;
            @(posedge clk); #1; lat++;
        end
        chk("latency", lat, exp_lat(op, b));
        chk("in_ready_low_busy", busy_ok, 1);
        dout = bus.alu_dout; flags = bus.alu_flags;
        chk("dout", dout, exp[31:16]);
        chk("flags", flags, exp[15:0]);
        chk("in_ready_low_done", bus.in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_dout", bus.alu_dout, exp[31:16]);
            chk("hold_flags", bus.alu_flags, exp[15:0]);
            chk("hold_in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("release_valid", bus.out_valid, 0);
        chk("release_in_ready", bus.in_ready, 1);
    endtask

    initial begin
        logic [15:0] d, f, a, b;
        logic [3:0] op;
        logic [15:0] edge_vals [5];
        edge_vals = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};

        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.alu_a_in = 16'h0; bus.alu_b_in = 16'h0; bus.alu_op = 4'h0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_dout", bus.alu_dout, 0);
        chk("rst_flags", bus.alu_flags, 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        run_op(4'd0, 16'hFFFF, 16'h0001, 0, d, f);
        chk("add_wrap_dout", d, 16'h0000);
        chk("add_wrap_flags", f, 16'h0005);
        run_op(4'd1, 16'h8000, 16'h0001, 0, d, f);
        chk("sub_ovf_dout", d, 16'h7FFF);
        chk("sub_ovf_flags", f, 16'h000C);
        run_op(4'd10, 16'h8000, 16'd20, 0, d, f);
        chk("sra_big_dout", d, 16'hFFFF);
        chk("sra_big_flags", f, 16'h0002);
        run_op(4'd11, 16'h1234, 16'h0100, 0, d, f);
        chk("mul_dout", d, 16'h3400);
        run_op(4'd12, 16'h1234, 16'h0100, 0, d, f);
        chk("mulh_dout", d, 16'h0012);
        run_op(4'd13, 16'd100, 16'd7, 0, d, f);
`ifdef ALU_DIV_EN
        chk("divu_dout", d, 16'd14);
        run_op(4'd14, 16'd100, 16'd7, 0, d, f);
        chk("remu_dout", d, 16'd2);
        run_op(4'd13, 16'd5, 16'd0, 0, d, f);
        chk("divz_dout", d, 16'hFFFF);
        chk("divz_flags", f, 16'h0012);
`else
        chk("divu_ill_dout", d, 16'h0000);
        chk("divu_ill_flags", f, 16'h0021);
`endif
        run_op(4'd0, 16'd3, 16'd4, 5, d, f);
        chk("bp_dout", d, 16'h0007);

        // Asynchronous reset in the middle of a multiply.
        cur_op = 11;
        bus.alu_op = 4'd11; bus.alu_a_in = 16'h1234; bus.alu_b_in = 16'h5678;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_in_ready", bus.in_ready, 1);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        run_op(4'd0, 16'd1, 16'd1, 0, d, f);
        chk("post_rst_add", d, 16'h0002);
        chk("post_rst_flags", f, 16'h0000);

        for (int n = 0; n < 80; n++) begin
            op = 4'($urandom_range(0, 15));
            a = 16'($urandom);
            b = 16'($urandom);
            if ($urandom_range(0, 3) == 0) a = edge_vals[$urandom_range(0, 4)];
            if ($urandom_range(0, 3) == 0) b = edge_vals[$urandom_range(0, 4)];
            if (op == 4'd2 || op == 4'd3 || op == 4'd10) b = 16'($urandom_range(0, 20));
            if ((op == 4'd13 || op == 4'd14) && $urandom_range(0, 4) == 0) b = 16'h0;
            run_op(op, a, b, $urandom_range(0, 2), d, f);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
